// File: rtl/alu_issue_sched.sv
// Oldest-first issue scheduler for the single-cycle ALU: buffers renamed ops, wakes sources
// from writeback broadcasts, and issues at most one ready op per cycle by age priority.

package alu_issue_sched_pkg;
  localparam int unsigned PHYS_REG_BITS = 6;
  localparam int unsigned ROB_TAG_BITS  = 6;

  typedef struct packed {
    logic [3:0]               alu_op;
    logic                     alu_src;
    logic [31:0]              immediate;
    logic [PHYS_REG_BITS-1:0] prd;
    logic [ROB_TAG_BITS-1:0]  rob_tag;
    logic                     reg_write;
  } rs_entry_t;
endpackage

module alu_issue_sched
  import alu_issue_sched_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned NUM_WAKEUP = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      dispatch_valid,
  output logic                                      dispatch_ready,
  input  rs_entry_t                                 dispatch_entry,
  input  logic [PHYS_REG_BITS-1:0]                  dispatch_prs1,
  input  logic [PHYS_REG_BITS-1:0]                  dispatch_prs2,
  input  logic                                      dispatch_rdy1,
  input  logic                                      dispatch_rdy2,
  input  logic [NUM_WAKEUP-1:0]                     wakeup_en,
  input  logic [NUM_WAKEUP-1:0][PHYS_REG_BITS-1:0]  wakeup_prd,
  input  logic                                      alu_ready,
  output logic                                      issue_en,
  output rs_entry_t                                 issue_entry,
  output logic [PHYS_REG_BITS-1:0]                  issue_prs1,
  output logic [PHYS_REG_BITS-1:0]                  issue_prs2,
  input  logic                                      flush,
  output logic [$clog2(DEPTH):0]                    occupancy
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = IdxW + 1;

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0]         rdy1_q, rdy1_d;
  logic [DEPTH-1:0]         rdy2_q, rdy2_d;
  rs_entry_t                ent_q  [DEPTH];
  rs_entry_t                ent_d  [DEPTH];
  logic [PHYS_REG_BITS-1:0] prs1_q [DEPTH];
  logic [PHYS_REG_BITS-1:0] prs1_d [DEPTH];
  logic [PHYS_REG_BITS-1:0] prs2_q [DEPTH];
  logic [PHYS_REG_BITS-1:0] prs2_d [DEPTH];
  // age_q[i][j] set means entry j is older than entry i
  logic [DEPTH-1:0]         age_q  [DEPTH];
  logic [DEPTH-1:0]         age_d  [DEPTH];

  logic [DEPTH-1:0] wake1, wake2;
  logic             disp_wake1, disp_wake2;
  logic [DEPTH-1:0] eligible, grant, issue_oh;
  logic [IdxW-1:0]  issue_idx, free_idx;
  logic             alloc;
  logic [CntW-1:0]  occ;

  always_comb begin
    wake1      = '0;
    wake2      = '0;
    disp_wake1 = 1'b0;
    disp_wake2 = 1'b0;
    for (int k = 0; k < NUM_WAKEUP; k++) begin
      if (wakeup_en[k]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wakeup_prd[k] == prs1_q[i]) wake1[i] = 1'b1;
          if (wakeup_prd[k] == prs2_q[i]) wake2[i] = 1'b1;
        end
        if (wakeup_prd[k] == dispatch_prs1) disp_wake1 = 1'b1;
        if (wakeup_prd[k] == dispatch_prs2) disp_wake2 = 1'b1;
      end
    end
  end

  // Ages form a total order over valid entries, so at most one grant bit is set.
  always_comb begin
    eligible = valid_q & rdy1_q & rdy2_q;
    grant    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = eligible[i] && ((age_q[i] & eligible) == '0);
    end
  end

  always_comb begin
    issue_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) issue_idx = IdxW'(i);
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IdxW'(i);
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + CntW'(valid_q[i]);
    end
  end

  assign occupancy      = occ;
  assign dispatch_ready = (occ < CntW'(DEPTH));
  assign issue_en       = alu_ready && (|eligible) && !flush;
  assign issue_oh       = issue_en ? grant : '0;
  assign alloc          = dispatch_valid && dispatch_ready && !flush;
  assign issue_entry    = ent_q[issue_idx];
  assign issue_prs1     = prs1_q[issue_idx];
  assign issue_prs2     = prs2_q[issue_idx];

  always_comb begin
    valid_d = valid_q & ~issue_oh;
    rdy1_d  = rdy1_q | (wake1 & valid_q);
    rdy2_d  = rdy2_q | (wake2 & valid_q);
    ent_d   = ent_q;
    prs1_d  = prs1_q;
    prs2_d  = prs2_q;
    age_d   = age_q;

    if (alloc) begin
      valid_d[free_idx] = 1'b1;
      ent_d[free_idx]   = dispatch_entry;
      prs1_d[free_idx]  = dispatch_prs1;
      prs2_d[free_idx]  = dispatch_prs2;
      rdy1_d[free_idx]  = dispatch_rdy1 | disp_wake1;
      rdy2_d[free_idx]  = dispatch_rdy2 | disp_wake2;
      // The newcomer is younger than every survivor; wipe stale bits of the previous occupant.
      for (int r = 0; r < DEPTH; r++) begin
        age_d[r][free_idx] = 1'b0;
      end
      age_d[free_idx] = valid_q & ~issue_oh;
    end

    if (flush) valid_d = '0;

    rdy1_d = rdy1_d & valid_d;
    rdy2_d = rdy2_d & valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i]  <= '0;
        prs1_q[i] <= '0;
        prs2_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i]  <= ent_d[i];
        prs1_q[i] <= prs1_d[i];
        prs2_q[i] <= prs2_d[i];
        age_q[i]  <= age_d[i];
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_sched.sv
// Scoreboard bench for alu_issue_sched: stimulus pushes expected issues, a negedge monitor
// pops and checks tag, source addresses and issue cycle.

module tb_alu_issue_sched;
  import alu_issue_sched_pkg::*;

  localparam int unsigned DEPTH      = 8;
  localparam int unsigned NUM_WAKEUP = 2;

  logic                                     clk = 1'b0;
  logic                                     rst;
  logic                                     dispatch_valid;
  logic                                     dispatch_ready;
  rs_entry_t                                dispatch_entry;
  logic [PHYS_REG_BITS-1:0]                 dispatch_prs1, dispatch_prs2;
  logic                                     dispatch_rdy1, dispatch_rdy2;
  logic [NUM_WAKEUP-1:0]                    wakeup_en;
  logic [NUM_WAKEUP-1:0][PHYS_REG_BITS-1:0] wakeup_prd;
  logic                                     alu_ready;
  logic                                     issue_en;
  rs_entry_t                                issue_entry;
  logic [PHYS_REG_BITS-1:0]                 issue_prs1, issue_prs2;
  logic                                     flush;
  logic [$clog2(DEPTH):0]                   occupancy;

  alu_issue_sched #(.DEPTH(DEPTH), .NUM_WAKEUP(NUM_WAKEUP)) dut (
    .clk            (clk),
    .rst            (rst),
    .dispatch_valid (dispatch_valid),
    .dispatch_ready (dispatch_ready),
    .dispatch_entry (dispatch_entry),
    .dispatch_prs1  (dispatch_prs1),
    .dispatch_prs2  (dispatch_prs2),
    .dispatch_rdy1  (dispatch_rdy1),
    .dispatch_rdy2  (dispatch_rdy2),
    .wakeup_en      (wakeup_en),
    .wakeup_prd     (wakeup_prd),
    .alu_ready      (alu_ready),
    .issue_en       (issue_en),
    .issue_entry    (issue_entry),
    .issue_prs1     (issue_prs1),
    .issue_prs2     (issue_prs2),
    .flush          (flush),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] rob;
    logic [5:0] p1;
    logic [5:0] p2;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_issue(input logic [5:0] rob, input logic [5:0] p1, input logic [5:0] p2,
                              input int at);
    exp_t e;
    e.rob = rob; e.p1 = p1; e.p2 = p2; e.cyc = at;
    exp_q.push_back(e);
  endtask

  // Monitor: every issue must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && issue_en) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_issue: got rob %0d at cycle %0d, required no issue",
                 issue_entry.rob_tag, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (issue_entry.rob_tag !== e.rob || issue_prs1 !== e.p1 || issue_prs2 !== e.p2 ||
            cyc != e.cyc) begin
          fails++;
          $display("FAIL issue: got rob %0d prs %0d/%0d cycle %0d, required rob %0d prs %0d/%0d cycle %0d",
                   issue_entry.rob_tag, issue_prs1, issue_prs2, cyc, e.rob, e.p1, e.p2, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [5:0] rob, input logic [5:0] p1, input logic r1,
                      input logic [5:0] p2, input logic r2);
    dispatch_valid           = 1'b1;
    dispatch_entry           = '0;
    dispatch_entry.rob_tag   = rob;
    dispatch_entry.prd       = rob;
    dispatch_entry.alu_op    = rob[3:0];
    dispatch_entry.reg_write = 1'b1;
    dispatch_prs1            = p1;
    dispatch_rdy1            = r1;
    dispatch_prs2            = p2;
    dispatch_rdy2            = r2;
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    wakeup_en      = '0;
    flush          = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1;
    dispatch_valid = 1'b0; dispatch_entry = '0;
    dispatch_prs1 = '0; dispatch_prs2 = '0; dispatch_rdy1 = 1'b0; dispatch_rdy2 = 1'b0;
    wakeup_en = '0; wakeup_prd = '0; alu_ready = 1'b1; flush = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset then idle
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_issue_en", issue_en, 0);
      check("reset_dispatch_ready", dispatch_ready, 1);
      check("reset_occupancy", occupancy, 0);
      if (i == 0) check("reset_issue_prs1", issue_prs1, 0);
      step();
    end

    // Three ready ops back-to-back issue in order, one cycle after each dispatch
    c = cyc;
    disp(5, 1, 1, 2, 1); expect_issue(5, 1, 2, c + 1); step();
    disp(6, 3, 1, 4, 1); expect_issue(6, 3, 4, c + 2); step();
    disp(7, 5, 1, 6, 1); expect_issue(7, 5, 6, c + 3); step();
    idle();
    repeat (4) step();

    // Younger ready op bypasses older waiting op; wakeup makes the older one eligible next cycle
    c = cyc;
    disp(10, 12, 0, 13, 1); step();
    disp(11, 14, 1, 15, 1); expect_issue(11, 14, 15, c + 2); step();
    idle(); step();
    wakeup_en[0] = 1'b1; wakeup_prd[0] = 12; expect_issue(10, 12, 13, c + 4); step();
    idle();
    repeat (4) step();

    // Fill all entries with waiting ops, attempt a dispatch while full, then wake them all
    c = cyc;
    for (int i = 0; i < DEPTH; i++) begin
      disp(6'(16 + i), 30, 0, 0, 1);
      step();
    end
    disp(31, 1, 1, 1, 1);
    @(negedge clk);
    check("full_occupancy", occupancy, DEPTH);
    check("full_dispatch_ready", dispatch_ready, 0);
    step();
    idle();
    wakeup_en[1] = 1'b1; wakeup_prd[1] = 30;
    for (int i = 0; i < DEPTH; i++) expect_issue(6'(16 + i), 30, 0, c + 10 + i);
    step();
    idle();
    @(negedge clk);
    check("full_still_not_ready", dispatch_ready, 0);
    step();
    @(negedge clk);
    check("ready_after_first_issue", dispatch_ready, 1);
    check("occupancy_after_first_issue", occupancy, DEPTH - 1);
    repeat (9) step();
    @(negedge clk);
    check("drained_occupancy", occupancy, 0);
    step();

    // Same-cycle wakeup on dispatch stores the source as ready
    c = cyc;
    disp(40, 3, 1, 20, 0);
    wakeup_en[0] = 1'b1; wakeup_prd[0] = 20;
    expect_issue(40, 3, 20, c + 1);
    step();
    idle();
    repeat (3) step();

    // Ready ops held by alu_ready=0, then flushed together with a concurrent dispatch
    alu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(6'(50 + i), 6'(40 + i), 1, 0, 1);
      step();
    end
    idle();
    @(negedge clk);
    check("stall_issue_en", issue_en, 0);
    check("stall_occupancy", occupancy, 4);
    step();
    alu_ready = 1'b1;
    flush = 1'b1;
    disp(54, 1, 1, 1, 1);
    @(negedge clk);
    check("flush_issue_en", issue_en, 0);
    step();
    idle();
    @(negedge clk);
    check("post_flush_occupancy", occupancy, 0);
    check("post_flush_issue_en", issue_en, 0);
    check("post_flush_dispatch_ready", dispatch_ready, 1);
    repeat (4) step();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_issue_sched.md
# alu_issue_sched

Oldest-first issue scheduler for the single-cycle ALU. It holds up to DEPTH renamed ALU ops, wakes their source operands from writeback tag broadcasts, and each cycle selects at most one ready op to issue. It sits between dispatch/rename and the ALU + PRF read ports. It shares the ALU among all buffered requesters by age priority.

## Interface
Parameters:
- DEPTH, 8, scheduler entries (power of two, ≥2)
- NUM_WAKEUP, 2, writeback tag broadcast ports

Ports:
- clk  in  1  clock; all state on posedge
- rst  in  1  synchronous, active-high reset
- dispatch_valid  in  1  new ALU op offered
- dispatch_ready  out  1  at least one free entry (registered occupancy)
- dispatch_entry  in  rs_entry_t  op payload (alu_op, alu_src, immediate, prd, rob_tag, reg_write)
- dispatch_prs1, dispatch_prs2  in  PHYS_REG_BITS  source physical tags
- dispatch_rdy1, dispatch_rdy2  in  1  source already valid at rename
- wakeup_en  in  NUM_WAKEUP  per-port broadcast valid
- wakeup_prd  in  NUM_WAKEUP×PHYS_REG_BITS  broadcast tags
- alu_ready  in  1  ALU can accept
- issue_en  out  1  op issued this cycle
- issue_entry  out  rs_entry_t  issued payload
- issue_prs1, issue_prs2  out  PHYS_REG_BITS  PRF read addresses (PRF read is combinational, same cycle)
- flush  in  1  discard all buffered ops
- occupancy  out  $clog2(DEPTH)+1  valid entry count

## Operation
- Per entry: valid, payload, prs1/prs2, rdy1/rdy2, DEPTH-bit age row (age[i][j]=1 ⇒ j older than i).
- Allocate: dispatch_valid && dispatch_ready && !flush ⇒ write lowest-index free entry; valid=1; age row = current valid vector (minus any entry issuing this cycle); clear column i in all rows.
- Dispatch-cycle wakeup: rdyN stored = dispatch_rdyN OR any wakeup_en[k] with wakeup_prd[k]==dispatch_prsN.
- Wakeup: for each valid entry, any matching wakeup_en[k]/wakeup_prd[k] sets rdy1/rdy2. rdy bits never clear except on free.
- Eligible[i] = valid && rdy1 && rdy2. Select i such that eligible[i] and no eligible j with age[i][j]. Exactly one or zero winners.
- issue_en = alu_ready && any eligible && !flush; issue_entry/prs from winner; winner freed (valid=0) at next edge.
- Values are don't-care when issue_en=0, but must be driven from entry 0 (no X).
- Flush: all valid cleared next edge; dispatch ignored that cycle; issue_en forced 0.
- occupancy = popcount(valid); dispatch_ready = occupancy<DEPTH, from registered state (a slot freed by issue this cycle is not reusable until next cycle).
- Simultaneous allocate+issue: occupancy unchanged.

## Timing
- Reset: all valid=0, rdy=0, age=0; issue_en=0, dispatch_ready=1, occupancy=0, issue_prs*=0.
- Dispatched op with both sources ready: earliest issue is the cycle after dispatch (1-cycle dispatch-to-issue).
- Wakeup in cycle t ⇒ eligible in t+1 (no same-cycle wakeup-to-issue bypass).
- ALU result for op issued in t broadcast at t+1 (ALU 1-cycle). The dependent issues at t+2.
- alu_ready=0: no issue, no state change to selected entry; selection re-evaluated next cycle.
- Full (occupancy==DEPTH): dispatch_ready=0; dispatch_valid ignored.
- rst dominates flush, dispatch, wakeup.

## Test plan
- Reset then idle: issue_en=0, dispatch_ready=1, occupancy=0 for 5 cycles.
- Dispatch 3 ready ops (rob_tag 5,6,7) on consecutive cycles: issue at cycles 1,2,3 after first dispatch, in order 5,6,7.
- Dispatch A (prs1=12 not ready) then B (ready): B issues first. Wakeup 12 at t ⇒ A issues t+1.
- Fill 8 entries, none ready: dispatch_ready=0, occupancy=8. Wake all via wakeup port 1 ⇒ 8 issues in dispatch order. dispatch_ready=1 after the first issue.
- Dispatch with prs2=20 while wakeup_prd[0]=20 same cycle ⇒ entry stored ready, issues next cycle.
- Flush with 4 valid entries plus concurrent dispatch: next cycle occupancy=0, issue_en=0, the dispatched op dropped.
